// File: rtl/rom_download_packer.sv
// Packs 16-bit HPS download words into 8-byte-masked 64-bit DDR3 writes.
// Optional macro ROM_BYTE_SWAP_EN: byte-swap each download word before packing.
module rom_download_packer #(
    parameter logic [7:0]  INDEX     = 8'd0,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        download_cs,
    input  logic        download_wr,
    input  logic [7:0]  download_index,
    input  logic [24:0] download_addr,
    input  logic [15:0] download_dout,
    output logic        download_waitReq,
    output logic        ddr_wr,
    output logic [31:0] ddr_addr,
    output logic [63:0] ddr_din,
    output logic [7:0]  ddr_mask,
    output logic [7:0]  ddr_burstLength,
    input  logic        ddr_waitReq,
    output logic        done
);

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_WRITE = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic [15:0] order_word(input logic [15:0] w);
`ifdef ROM_BYTE_SWAP_EN
        order_word = {w[7:0], w[15:8]};
`else
        order_word = w;
`endif
    endfunction

    function automatic logic [63:0] merge_lane(input logic [63:0] data_in,
                                               input logic [1:0]  lane,
                                               input logic [15:0] w);
        logic [63:0] r;
        r = data_in;
        case (lane)
            2'd0:    r[15:0]  = w;
            2'd1:    r[31:16] = w;
            2'd2:    r[47:32] = w;
            2'd3:    r[63:48] = w;
            default: r = data_in;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] lane_mask(input logic [1:0] lane);
        case (lane)
            2'd0:    lane_mask = 8'b0000_0011;
            2'd1:    lane_mask = 8'b0000_1100;
            2'd2:    lane_mask = 8'b0011_0000;
            2'd3:    lane_mask = 8'b1100_0000;
            default: lane_mask = 8'b0000_0000;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [63:0] data_q, data_d;
    logic [7:0]  mask_q, mask_d;
    logic [21:0] qaddr_q, qaddr_d;
    logic        skid_vld_q, skid_vld_d;
    logic [15:0] skid_word_q, skid_word_d;
    logic [21:0] skid_qaddr_q, skid_qaddr_d;
    logic [1:0]  skid_lane_q, skid_lane_d;
    logic        cs_prev_q, cs_prev_d;
    logic        fall_pend_q, fall_pend_d;
    logic        wait_q, wait_d;
    logic        ddr_wr_q, ddr_wr_d;
    logic [31:0] ddr_addr_q, ddr_addr_d;
    logic [63:0] ddr_din_q, ddr_din_d;
    logic [7:0]  ddr_mask_q, ddr_mask_d;
    logic        done_q, done_d;

    logic        idx_match_s;
    logic        accept_s;
    logic        cs_fall_s;
    logic        ddr_ack_s;
    logic [21:0] in_qaddr_s;
    logic [1:0]  in_lane_s;
    logic [15:0] in_word_s;
    logic        unused_addr0_s;

    assign idx_match_s    = (download_index == INDEX);
    assign accept_s       = download_wr & download_cs & idx_match_s & ~wait_q;
    assign cs_fall_s      = cs_prev_q & ~download_cs;
    assign ddr_ack_s      = ddr_wr_q & ~ddr_waitReq;
    assign in_qaddr_s     = download_addr[24:3];
    assign in_lane_s      = download_addr[2:1];
    assign in_word_s      = order_word(download_dout);
    assign unused_addr0_s = download_addr[0];

    // Next-state, buffer/skid update and registered output computation.
    always_comb begin
        state_d      = state_q;
        data_d       = data_q;
        mask_d       = mask_q;
        qaddr_d      = qaddr_q;
        skid_vld_d   = skid_vld_q;
        skid_word_d  = skid_word_q;
        skid_qaddr_d = skid_qaddr_q;
        skid_lane_d  = skid_lane_q;
        fall_pend_d  = fall_pend_q;
        cs_prev_d    = download_cs & idx_match_s;

        case (state_q)
            ST_FILL: begin
                if (cs_fall_s || fall_pend_q) begin
                    fall_pend_d = 1'b0;
                    if (mask_q != 8'd0) begin
                        state_d = ST_FLUSH;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else if (accept_s) begin
                    if ((mask_q == 8'd0) || (in_qaddr_s == qaddr_q)) begin
                        data_d  = merge_lane(data_q, in_lane_s, in_word_s);
                        mask_d  = mask_q | lane_mask(in_lane_s);
                        qaddr_d = in_qaddr_s;
                        if (in_lane_s == 2'd3) begin
                            state_d = ST_WRITE;
                        end else begin
                            state_d = ST_FILL;
                        end
                    end else begin
                        // Address jump: park the new word, commit the old partial qword.
                        skid_vld_d   = 1'b1;
                        skid_word_d  = in_word_s;
                        skid_qaddr_d = in_qaddr_s;
                        skid_lane_d  = in_lane_s;
                        state_d      = ST_WRITE;
                    end
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_WRITE, ST_FLUSH: begin
                if ((state_q == ST_WRITE) && cs_fall_s) begin
                    fall_pend_d = 1'b1;
                end else begin
                    fall_pend_d = fall_pend_q;
                end
                if (ddr_ack_s) begin
                    if (skid_vld_q) begin
                        data_d     = merge_lane(64'd0, skid_lane_q, skid_word_q);
                        mask_d     = lane_mask(skid_lane_q);
                        qaddr_d    = skid_qaddr_q;
                        skid_vld_d = 1'b0;
                        if (state_q == ST_FLUSH) begin
                            state_d = ST_FLUSH;
                        end else if (skid_lane_q == 2'd3) begin
                            state_d = ST_WRITE;
                        end else begin
                            state_d = ST_FILL;
                        end
                    end else begin
                        data_d = 64'd0;
                        mask_d = 8'd0;
                        if (state_q == ST_FLUSH) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_FILL;
                        end
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_DONE: begin
                state_d = ST_FILL;
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase

        ddr_wr_d = (state_d == ST_WRITE) || (state_d == ST_FLUSH);
        if (ddr_wr_d) begin
            ddr_addr_d = BASE_ADDR + {7'd0, qaddr_d, 3'd0};
            ddr_din_d  = data_d;
            ddr_mask_d = mask_d;
        end else begin
            ddr_addr_d = 32'd0;
            ddr_din_d  = 64'd0;
            ddr_mask_d = 8'd0;
        end

        // Stall stays up one extra cycle after returning to FILL.
        wait_d = (state_q != ST_FILL) || (state_d != ST_FILL);
        done_d = (state_d == ST_DONE);
    end

    // State, buffer, skid and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_FILL;
            data_q       <= 64'd0;
            mask_q       <= 8'd0;
            qaddr_q      <= 22'd0;
            skid_vld_q   <= 1'b0;
            skid_word_q  <= 16'd0;
            skid_qaddr_q <= 22'd0;
            skid_lane_q  <= 2'd0;
            cs_prev_q    <= 1'b0;
            fall_pend_q  <= 1'b0;
            wait_q       <= 1'b0;
            ddr_wr_q     <= 1'b0;
            ddr_addr_q   <= 32'd0;
            ddr_din_q    <= 64'd0;
            ddr_mask_q   <= 8'd0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            data_q       <= data_d;
            mask_q       <= mask_d;
            qaddr_q      <= qaddr_d;
            skid_vld_q   <= skid_vld_d;
            skid_word_q  <= skid_word_d;
            skid_qaddr_q <= skid_qaddr_d;
            skid_lane_q  <= skid_lane_d;
            cs_prev_q    <= cs_prev_d;
            fall_pend_q  <= fall_pend_d;
            wait_q       <= wait_d;
            ddr_wr_q     <= ddr_wr_d;
            ddr_addr_q   <= ddr_addr_d;
            ddr_din_q    <= ddr_din_d;
            ddr_mask_q   <= ddr_mask_d;
            done_q       <= done_d;
        end
    end

    assign download_waitReq = wait_q;
    assign ddr_wr           = ddr_wr_q;
    assign ddr_addr         = ddr_addr_q;
    assign ddr_din          = ddr_din_q;
    assign ddr_mask         = ddr_mask_q;
    assign ddr_burstLength  = 8'd1;
    assign done             = done_q;

endmodule

// File: tb/tb_rom_download_packer.sv
// Bench for rom_download_packer: directed table, hand-written corner sequences,
// and randomized downloads checked against a qword-grouping reference model.
module tb_rom_download_packer;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clock;
    logic        reset_n;
    logic        download_cs;
    logic        download_wr;
    logic [7:0]  download_index;
    logic [24:0] download_addr;
    logic [15:0] download_dout;
    logic        download_waitReq;
    logic        ddr_wr;
    logic [31:0] ddr_addr;
    logic [63:0] ddr_din;
    logic [7:0]  ddr_mask;
    logic [7:0]  ddr_burstLength;
    logic        ddr_waitReq;
    logic        done;

    rom_download_packer dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .download_cs      (download_cs),
        .download_wr      (download_wr),
        .download_index   (download_index),
        .download_addr    (download_addr),
        .download_dout    (download_dout),
        .download_waitReq (download_waitReq),
        .ddr_wr           (ddr_wr),
        .ddr_addr         (ddr_addr),
        .ddr_din          (ddr_din),
        .ddr_mask         (ddr_mask),
        .ddr_burstLength  (ddr_burstLength),
        .ddr_waitReq      (ddr_waitReq),
        .done             (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int vectors = 0;
    int errors  = 0;
    int bp_mode = 0;   // 0: DDR ready, 1: DDR busy, 2: random busy

    logic [24:0] dl_a[$];
    logic [15:0] dl_d[$];
    logic [31:0] exp_a[$];
    logic [63:0] exp_d[$];
    logic [7:0]  exp_m[$];
    logic [31:0] cap_a[$];
    logic [63:0] cap_d[$];
    logic [7:0]  cap_m[$];
    int done_cnt    = 0;
    int wait_hi_cnt = 0;

    typedef struct {
        int              n;
        logic [7:0]      idx;
        logic [3:0][24:0] a;
        logic [3:0][15:0] d;
        int              nw;
        logic [1:0][31:0] ea;
        logic [1:0][63:0] ed;
        logic [1:0][7:0]  em;
        int              nd;
    } vec_t;

    vec_t vecs[9];

    function automatic logic [15:0] sw16(input logic [15:0] w);
`ifdef ROM_BYTE_SWAP_EN
        return {w[7:0], w[15:8]};
`else
        return w;
`endif
    endfunction

    function automatic logic [63:0] sw64(input logic [63:0] v);
        return {sw16(v[63:48]), sw16(v[47:32]), sw16(v[31:16]), sw16(v[15:0])};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // DDR busy driver, changes 2 time units after each rising edge.
    initial begin
        ddr_waitReq = 1'b0;
        forever begin
            @(posedge clock);
            #2;
            case (bp_mode)
                0:       ddr_waitReq = 1'b0;
                1:       ddr_waitReq = 1'b1;
                default: ddr_waitReq = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Capture accepted DDR writes and done pulses on the falling edge.
    always @(negedge clock) begin
        if (reset_n) begin
            if (ddr_wr && !ddr_waitReq) begin
                cap_a.push_back(ddr_addr);
                cap_d.push_back(ddr_din);
                cap_m.push_back(ddr_mask);
            end
            if (done) done_cnt++;
            if (download_waitReq) wait_hi_cnt++;
        end
    end

    task automatic put_word(input logic [24:0] a, input logic [15:0] d);
        int t;
        t = 0;
        while (download_waitReq && t < 300) begin
            @(posedge clock); #1;
            t++;
        end
        if (t >= 300) chk("put_timeout", 64'(t), 64'd0);
        download_addr = a;
        download_dout = d;
        download_wr   = 1'b1;
        @(posedge clock); #1;
        download_wr   = 1'b0;
    endtask

    task automatic run_download(input logic [7:0] idx, input int max_gap);
        download_index = idx;
        download_cs    = 1'b1;
        @(posedge clock); #1;
        for (int i = 0; i < dl_a.size(); i++) begin
            repeat ($urandom_range(0, max_gap)) begin
                @(posedge clock); #1;
            end
            put_word(dl_a[i], dl_d[i]);
        end
        download_cs = 1'b0;
        @(posedge clock); #1;
    endtask

    // Reference: words group by qword; a qword is written when lane 3 lands,
    // when the next word targets another qword, or when the download ends.
    task automatic build_expected();
        logic [63:0] data;
        logic [7:0]  m;
        logic [21:0] cq;
        logic [21:0] q;
        int          l;
        exp_a.delete(); exp_d.delete(); exp_m.delete();
        data = 64'd0; m = 8'd0; cq = 22'd0;
        for (int i = 0; i < dl_a.size(); i++) begin
            q = dl_a[i][24:3];
            l = int'(dl_a[i][2:1]);
            if (m != 8'd0 && q != cq) begin
                exp_a.push_back(BASE + {7'd0, cq, 3'd0}); exp_d.push_back(data); exp_m.push_back(m);
                data = 64'd0; m = 8'd0;
            end
            cq = q;
            data[16*l +: 16] = sw16(dl_d[i]);
            m[2*l +: 2] = 2'b11;
            if (l == 3) begin
                exp_a.push_back(BASE + {7'd0, cq, 3'd0}); exp_d.push_back(data); exp_m.push_back(m);
                data = 64'd0; m = 8'd0;
            end
        end
        if (m != 8'd0) begin
            exp_a.push_back(BASE + {7'd0, cq, 3'd0}); exp_d.push_back(data); exp_m.push_back(m);
        end
    endtask

    task automatic check_run(input int base, input int d0, input int exp_done, input string tag);
        int t;
        t = 0;
        while ((done_cnt - d0) < exp_done && t < 400) begin
            @(posedge clock); #1;
            t++;
        end
        repeat (8) begin
            @(posedge clock); #1;
        end
        chk({tag, "_nwr"}, 64'(cap_a.size() - base), 64'(exp_a.size()));
        for (int i = 0; i < exp_a.size() && (base + i) < cap_a.size(); i++) begin
            chk($sformatf("%s_addr%0d", tag, i), 64'(cap_a[base + i]), 64'(exp_a[i]));
            chk($sformatf("%s_din%0d", tag, i), cap_d[base + i], exp_d[i]);
            chk($sformatf("%s_mask%0d", tag, i), 64'(cap_m[base + i]), 64'(exp_m[i]));
        end
        chk({tag, "_done"}, 64'(done_cnt - d0), 64'(exp_done));
    endtask

    task automatic exp_one(input logic [31:0] a, input logic [63:0] d, input logic [7:0] m);
        exp_a.delete(); exp_d.delete(); exp_m.delete();
        exp_a.push_back(a); exp_d.push_back(sw64(d)); exp_m.push_back(m);
    endtask

    initial begin
        int base;
        int d0;
        int w0;
        int nwords;
        int p;
        logic [24:0] a;
        logic [7:0]  ix;

        // Table entries list words/expected writes MSB-first: a[3]..a[0].
        vecs[0] = '{n:4, idx:8'd0, a:{25'h6, 25'h4, 25'h2, 25'h0},
                    d:{16'h4444, 16'h3333, 16'h2222, 16'h1111}, nw:1,
                    ea:{32'h0, 32'h3000_0000}, ed:{64'h0, 64'h4444_3333_2222_1111},
                    em:{8'h0, 8'hFF}, nd:1};
        vecs[1] = '{n:2, idx:8'd0, a:{25'h0, 25'h0, 25'hA, 25'h8},
                    d:{16'h0, 16'h0, 16'hDDDD, 16'hCCCC}, nw:1,
                    ea:{32'h0, 32'h3000_0008}, ed:{64'h0, 64'h0000_0000_DDDD_CCCC},
                    em:{8'h0, 8'h0F}, nd:1};
        vecs[2] = '{n:2, idx:8'd0, a:{25'h0, 25'h0, 25'h10, 25'h0},
                    d:{16'h0, 16'h0, 16'hBBBB, 16'hAAAA}, nw:2,
                    ea:{32'h3000_0010, 32'h3000_0000},
                    ed:{64'h0000_0000_0000_BBBB, 64'h0000_0000_0000_AAAA},
                    em:{8'h03, 8'h03}, nd:1};
        vecs[3] = '{n:3, idx:8'd0, a:{25'h0, 25'h32, 25'h30, 25'h30},
                    d:{16'h0, 16'h0003, 16'h0002, 16'h0001}, nw:1,
                    ea:{32'h0, 32'h3000_0030}, ed:{64'h0, 64'h0000_0000_0003_0002},
                    em:{8'h0, 8'h0F}, nd:1};
        vecs[4] = '{n:2, idx:8'd0, a:{25'h0, 25'h0, 25'h1FF_FFFC, 25'h1FF_FFFA},
                    d:{16'h0, 16'h0, 16'hA5A5, 16'h5A5A}, nw:1,
                    ea:{32'h0, 32'h31FF_FFF8}, ed:{64'h0, 64'h0000_A5A5_5A5A_0000},
                    em:{8'h0, 8'h3C}, nd:1};
        vecs[5] = '{n:1, idx:8'd0, a:{25'h0, 25'h0, 25'h0, 25'h41},
                    d:{16'h0, 16'h0, 16'h0, 16'hBEEF}, nw:1,
                    ea:{32'h0, 32'h3000_0040}, ed:{64'h0, 64'h0000_0000_0000_BEEF},
                    em:{8'h0, 8'h03}, nd:1};
        vecs[6] = '{n:4, idx:8'd1, a:{25'h6, 25'h4, 25'h2, 25'h0},
                    d:{16'h4444, 16'h3333, 16'h2222, 16'h1111}, nw:0,
                    ea:{32'h0, 32'h0}, ed:{64'h0, 64'h0}, em:{8'h0, 8'h0}, nd:0};
        vecs[7] = '{n:2, idx:8'd0, a:{25'h0, 25'h0, 25'h5E, 25'h50},
                    d:{16'h0, 16'h0, 16'h5678, 16'h1234}, nw:2,
                    ea:{32'h3000_0058, 32'h3000_0050},
                    ed:{64'h5678_0000_0000_0000, 64'h0000_0000_0000_1234},
                    em:{8'hC0, 8'h03}, nd:1};
        vecs[8] = '{n:0, idx:8'd0, a:{25'h0, 25'h0, 25'h0, 25'h0},
                    d:{16'h0, 16'h0, 16'h0, 16'h0}, nw:0,
                    ea:{32'h0, 32'h0}, ed:{64'h0, 64'h0}, em:{8'h0, 8'h0}, nd:1};

        reset_n = 1'b0; download_cs = 1'b0; download_wr = 1'b0;
        download_index = 8'd0; download_addr = 25'd0; download_dout = 16'd0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_ddr_wr", 64'(ddr_wr), 64'd0);
        chk("rst_waitreq", 64'(download_waitReq), 64'd0);
        chk("rst_mask", 64'(ddr_mask), 64'd0);
        chk("rst_din", ddr_din, 64'd0);
        chk("rst_addr", 64'(ddr_addr), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_burst", 64'(ddr_burstLength), 64'd1);
        @(posedge clock); #1;
        reset_n = 1'b1;
        repeat (2) begin
            @(posedge clock); #1;
        end

        // Sequential fill: cycle-exact write and stall timing.
        bp_mode = 0;
        base = cap_a.size(); d0 = done_cnt;
        download_index = 8'd0; download_cs = 1'b1;
        @(posedge clock); #1;
        put_word(25'h100, 16'h1111);
        put_word(25'h102, 16'h2222);
        put_word(25'h104, 16'h3333);
        put_word(25'h106, 16'h4444);
        @(negedge clock);
        chk("lat_wr1", 64'(ddr_wr), 64'd1);
        chk("lat_wq1", 64'(download_waitReq), 64'd1);
        chk("lat_addr", 64'(ddr_addr), 64'h3000_0100);
        chk("lat_din", ddr_din, sw64(64'h4444_3333_2222_1111));
        chk("lat_mask", 64'(ddr_mask), 64'hFF);
        @(posedge clock); #1;
        @(negedge clock);
        chk("lat_wr2", 64'(ddr_wr), 64'd0);
        chk("lat_wq2", 64'(download_waitReq), 64'd1);
        @(posedge clock); #1;
        @(negedge clock);
        chk("lat_wq3", 64'(download_waitReq), 64'd0);
        @(posedge clock); #1;
        download_cs = 1'b0;
        @(posedge clock); #1;
        exp_one(32'h3000_0100, 64'h4444_3333_2222_1111, 8'hFF);
        check_run(base, d0, 1, "lat");

        // Backpressure: DDR busy 5 cycles, request must hold 6 cycles.
        bp_mode = 1;
        base = cap_a.size(); d0 = done_cnt;
        download_cs = 1'b1;
        @(posedge clock); #1;
        put_word(25'h40, 16'hA1A1);
        put_word(25'h42, 16'hB2B2);
        put_word(25'h44, 16'hC3C3);
        put_word(25'h46, 16'hD4D4);
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            chk($sformatf("bp_wr%0d", i), 64'(ddr_wr), 64'd1);
            chk($sformatf("bp_addr%0d", i), 64'(ddr_addr), 64'h3000_0040);
            chk($sformatf("bp_din%0d", i), ddr_din, sw64(64'hD4D4_C3C3_B2B2_A1A1));
            if (i == 4) chk("bp_noacc", 64'(cap_a.size() - base), 64'd0);
            @(posedge clock); #1;
            if (i == 4) bp_mode = 0;
        end
        @(negedge clock);
        chk("bp_wr_off", 64'(ddr_wr), 64'd0);
        @(posedge clock); #1;
        download_cs = 1'b0;
        @(posedge clock); #1;
        exp_one(32'h3000_0040, 64'hD4D4_C3C3_B2B2_A1A1, 8'hFF);
        check_run(base, d0, 1, "bp");

        // Reset while a write is stalled, then a clean fill.
        bp_mode = 1;
        download_cs = 1'b1;
        @(posedge clock); #1;
        put_word(25'h0, 16'h1234);
        put_word(25'h2, 16'h5678);
        put_word(25'h4, 16'h9ABC);
        put_word(25'h6, 16'hDEF0);
        @(negedge clock);
        chk("rm_pre_wr", 64'(ddr_wr), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("rm_wr", 64'(ddr_wr), 64'd0);
        chk("rm_mask", 64'(ddr_mask), 64'd0);
        download_cs = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset_n = 1'b1;
        bp_mode = 0;
        @(posedge clock); #1;
        base = cap_a.size(); d0 = done_cnt;
        dl_a.delete(); dl_d.delete();
        dl_a = '{25'h20, 25'h22, 25'h24, 25'h26};
        dl_d = '{16'h1234, 16'h0F0F, 16'hF0F0, 16'h5555};
        run_download(8'd0, 0);
        exp_one(32'h3000_0020, 64'h5555_F0F0_0F0F_1234, 8'hFF);
        check_run(base, d0, 1, "rm");

        // Directed table.
        for (int v = 0; v < 9; v++) begin
            bp_mode = (v % 2 == 0) ? 0 : 2;
            dl_a.delete(); dl_d.delete();
            for (int k = 0; k < vecs[v].n; k++) begin
                dl_a.push_back(vecs[v].a[k]);
                dl_d.push_back(vecs[v].d[k]);
            end
            exp_a.delete(); exp_d.delete(); exp_m.delete();
            for (int k = 0; k < vecs[v].nw; k++) begin
                exp_a.push_back(vecs[v].ea[k]);
                exp_d.push_back(sw64(vecs[v].ed[k]));
                exp_m.push_back(vecs[v].em[k]);
            end
            base = cap_a.size(); d0 = done_cnt; w0 = wait_hi_cnt;
            run_download(vecs[v].idx, 0);
            check_run(base, d0, vecs[v].nd, $sformatf("tab%0d", v));
            if (vecs[v].idx != 8'd0)
                chk($sformatf("tab%0d_wait", v), 64'(wait_hi_cnt - w0), 64'd0);
        end

        // Randomized downloads against the reference model.
        for (int r = 0; r < 30; r++) begin
            bp_mode = (r % 2 == 0) ? 0 : 2;
            ix = ($urandom_range(0, 9) == 0) ? 8'd1 : 8'd0;
            nwords = $urandom_range(1, 16);
            a = 25'($urandom_range(0, 32'h1FF_FFFF));
            dl_a.delete(); dl_d.delete();
            for (int k = 0; k < nwords; k++) begin
                dl_a.push_back(a);
                dl_d.push_back(16'($urandom));
                p = $urandom_range(0, 99);
                if (p < 70)      a = a + 25'd2;
                else if (p < 92) a = 25'($urandom_range(0, 32'h1FF_FFFF));
            end
            if (ix == 8'd0) begin
                build_expected();
            end else begin
                exp_a.delete(); exp_d.delete(); exp_m.delete();
            end
            base = cap_a.size(); d0 = done_cnt;
            run_download(ix, r % 3);
            check_run(base, d0, (ix == 8'd0) ? 1 : 0, $sformatf("rnd%0d", r));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
